// File: rtl/seg7_scan_if.sv
// seg7_scan_if: valid/ready load channel carrying the packed multi-digit display value.
interface seg7_scan_if #(
  parameter int unsigned DIGITS = 4
);
  logic [4*DIGITS-1:0] iv_data;
  logic                i_valid;
  logic                o_ready;

  modport master (output iv_data, output i_valid, input o_ready);
  modport slave  (input iv_data, input i_valid, output o_ready);
endinterface

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed common-anode 7-segment scanner with frame-aligned (tear-free) updates.
// Optional leading-zero blanking is enabled by defining SEG7_SCAN_LZB_EN.
module seg7_scan #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  seg7_scan_if.slave        bus,
  input  logic              i_enable,
  output logic [3:0]        ov_nibble,
  output logic [DIGITS-1:0] ov_digit_n,
  output logic              o_frame
);
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned DW = 4 * DIGITS;

  logic [PW-1:0]     presc_q, presc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DW-1:0]     shadow_q, shadow_d;
  logic [DW-1:0]     pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  logic              ready_q, ready_d;
  logic [3:0]        nibble_q, nibble_d;
  logic [DIGITS-1:0] digit_n_q, digit_n_d;
  logic              frame_q, frame_d;

  logic              tick_wrap_c, frame_end_c, xfer_c, commit_c;
  logic [DIGITS-1:0] lz_blank_c;

  // Scan timing, handshake capture and frame-boundary commit.
  always_comb begin
    presc_d    = presc_q;
    idx_d      = idx_q;
    shadow_d   = shadow_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ready_d    = ready_q;

    tick_wrap_c = (presc_q == PW'(TICK_DIV - 1));
    frame_end_c = tick_wrap_c && (idx_q == IW'(DIGITS - 1));
    xfer_c      = bus.i_valid && ready_q;
    commit_c    = frame_end_c && pend_vld_q;

    presc_d = tick_wrap_c ? '0 : presc_q + PW'(1);
    if (tick_wrap_c) begin
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end

    // ready is low whenever data is pending, so commit and capture never coincide
    if (commit_c) begin
      shadow_d   = pend_q;
      pend_vld_d = 1'b0;
      ready_d    = 1'b1;
    end else if (xfer_c) begin
      pend_d     = bus.iv_data;
      pend_vld_d = 1'b1;
      ready_d    = 1'b0;
    end

    frame_d = frame_end_c;
  end

`ifdef SEG7_SCAN_LZB_EN
  logic zero_above_c;

  // A digit above 0 is blanked when it and every higher digit of the shadow are zero.
  always_comb begin
    lz_blank_c   = '0;
    zero_above_c = 1'b1;
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
      zero_above_c = zero_above_c && (shadow_d[4*k +: 4] == 4'h0);
      if (k > 0) begin
        lz_blank_c[k] = zero_above_c;
      end
    end
  end
`else
  assign lz_blank_c = '0;
`endif

  // Look ahead at next index/shadow so nibble and select change together with the index.
  always_comb begin
    nibble_d  = '0;
    digit_n_d = '1;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (idx_d == IW'(k)) begin
        nibble_d = shadow_d[4*k +: 4];
        if (i_enable && (presc_d >= PW'(BLANK_CYCLES)) && !lz_blank_c[k]) begin
          digit_n_d[k] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc_q    <= '0;
      idx_q      <= '0;
      shadow_q   <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      ready_q    <= 1'b1;
      nibble_q   <= '0;
      digit_n_q  <= '1;
      frame_q    <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      ready_q    <= ready_d;
      nibble_q   <= nibble_d;
      digit_n_q  <= digit_n_d;
      frame_q    <= frame_d;
    end
  end

  assign bus.o_ready = ready_q;
  assign ov_nibble   = nibble_q;
  assign ov_digit_n  = digit_n_q;
  assign o_frame     = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: self-checking bench for seg7_scan with DIGITS=4, TICK_DIV=8, BLANK_CYCLES=2.
// Expected values come from elapsed-cycle arithmetic plus constant frame tables.
module tb_seg7_scan;
  localparam int DIGITS = 4;
  localparam int TICK   = 8;
  localparam int BLANK  = 2;
  localparam int FRAME  = DIGITS * TICK;
  localparam logic [15:0] SEL_ALL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  typedef struct packed {
    logic [15:0]     data;
    logic [3:0][3:0] nib;
    logic [3:0][3:0] sel;
  } vec_t;

  logic       i_clk, i_rst_n, i_enable;
  logic [3:0] ov_nibble;
  logic [3:0] ov_digit_n;
  logic       o_frame;

  seg7_scan_if #(.DIGITS(DIGITS)) bus ();

  seg7_scan #(
    .DIGITS      (DIGITS),
    .TICK_DIV    (TICK),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .bus       (bus),
    .i_enable  (i_enable),
    .ov_nibble (ov_nibble),
    .ov_digit_n(ov_digit_n),
    .o_frame   (o_frame)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int          checks;
  int          failures;
  int          n;
  logic [15:0] m_shadow, m_pend;
  logic        m_pflag, m_ready, m_en, m_xfer;
  vec_t        tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, n, act, exp);
    end
  endtask

  task automatic model_reset();
    n        = 0;
    m_shadow = '0;
    m_pend   = '0;
    m_pflag  = 1'b0;
    m_ready  = 1'b1;
    m_en     = 1'b1;
    m_xfer   = 1'b0;
  endtask

  // One rising edge: a frame ends every FRAME edges counted from reset release.
  task automatic model_edge();
    logic boundary;
    boundary = (((n + 1) % FRAME) == 0);
    m_xfer   = bus.i_valid && m_ready;
    if (boundary && m_pflag) begin
      m_shadow = m_pend;
      m_pflag  = 1'b0;
      m_ready  = 1'b1;
    end else if (m_xfer) begin
      m_pend  = bus.iv_data;
      m_pflag = 1'b1;
      m_ready = 1'b0;
    end
    m_en = i_enable;
    n++;
  endtask

  function automatic logic [3:0] exp_nib();
    int idx;
    idx = (n / TICK) % DIGITS;
    return 4'(m_shadow >> (4 * idx));
  endfunction

  function automatic logic [3:0] exp_digit();
    int         presc, idx;
    logic [3:0] d;
    presc = n % TICK;
    idx   = (n / TICK) % DIGITS;
    d     = 4'hF;
    if (m_en && presc >= BLANK) d[idx] = 1'b0;
`ifdef SEG7_SCAN_LZB_EN
    if (idx > 0 && (m_shadow >> (4 * idx)) == 16'h0) d = 4'hF;
`endif
    return d;
  endfunction

  task automatic compare_model();
    check("model_nibble", 32'(ov_nibble), 32'(exp_nib()));
    check("model_digit_n", 32'(ov_digit_n), 32'(exp_digit()));
    check("model_frame", 32'(o_frame), 32'(n > 0 && (n % FRAME) == 0));
    check("model_ready", 32'(bus.o_ready), 32'(m_ready));
  endtask

  task automatic tick();
    @(posedge i_clk);
    model_edge();
    @(negedge i_clk);
    compare_model();
  endtask

  task automatic send(input logic [15:0] d);
    bus.iv_data = d;
    bus.i_valid = 1'b1;
    tick();
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (!bus.o_ready && cyc < 2 * FRAME + 4) begin
      tick();
      cyc++;
    end
    check("ready_timeout", 32'(bus.o_ready), 32'd1);
  endtask

  // Starting at the first cycle of a frame, compare one whole frame against a table row.
  task automatic check_frame(input int r);
    int slot, p;
    for (int c = 0; c < FRAME; c++) begin
      if (c > 0) begin
        tick();
        bus.i_valid = 1'b0;
      end
      slot = c / TICK;
      p    = c % TICK;
      check("tbl_nibble", 32'(ov_nibble), 32'(tbl[r].nib[slot]));
      check("tbl_digit_n", 32'(ov_digit_n), (p < BLANK) ? 32'hF : 32'(tbl[r].sel[slot]));
      check("tbl_frame", 32'(o_frame), 32'(c == 0));
    end
  endtask

  task automatic do_reset();
    #2 i_rst_n = 1'b0;
    #1;
    check("rst_digit_n", 32'(ov_digit_n), 32'hF);
    check("rst_nibble", 32'(ov_nibble), 32'h0);
    check("rst_ready", 32'(bus.o_ready), 32'd1);
    check("rst_frame", 32'(o_frame), 32'd0);
    bus.i_valid = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    model_reset();
    compare_model();
  endtask

  initial begin
    int cyc;
    checks      = 0;
    failures    = 0;
    i_enable    = 1'b1;
    bus.i_valid = 1'b0;
    bus.iv_data = '0;
    i_rst_n     = 1'b1;
    model_reset();

    tbl[0] = '{data: 16'h1234, nib: {4'h1, 4'h2, 4'h3, 4'h4}, sel: SEL_ALL};
    tbl[1] = '{data: 16'hABCD, nib: {4'hA, 4'hB, 4'hC, 4'hD}, sel: SEL_ALL};
    tbl[2] = '{data: 16'h5555, nib: {4'h5, 4'h5, 4'h5, 4'h5}, sel: SEL_ALL};
`ifdef SEG7_SCAN_LZB_EN
    tbl[3] = '{data: 16'h0050, nib: {4'h0, 4'h0, 4'h5, 4'h0},
               sel: {4'b1111, 4'b1111, 4'b1101, 4'b1110}};
    tbl[4] = '{data: 16'h0000, nib: {4'h0, 4'h0, 4'h0, 4'h0},
               sel: {4'b1111, 4'b1111, 4'b1111, 4'b1110}};
`else
    tbl[3] = '{data: 16'h0050, nib: {4'h0, 4'h0, 4'h5, 4'h0}, sel: SEL_ALL};
    tbl[4] = '{data: 16'h0000, nib: {4'h0, 4'h0, 4'h0, 4'h0}, sel: SEL_ALL};
`endif
    tbl[5] = '{data: 16'h1000, nib: {4'h1, 4'h0, 4'h0, 4'h0}, sel: SEL_ALL};

    // Power-on reset
    #1 i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check("por_digit_n", 32'(ov_digit_n), 32'hF);
    check("por_nibble", 32'(ov_nibble), 32'h0);
    check("por_ready", 32'(bus.o_ready), 32'd1);
    check("por_frame", 32'(o_frame), 32'd0);
    i_rst_n = 1'b1;
    model_reset();
    compare_model();

    // Asynchronous reset mid-slot, then mid-handshake with pending data discarded
    repeat (13) tick();
    do_reset();
    repeat (3) tick();
    send(16'h9876);
    repeat (2) tick();
    do_reset();
    repeat (FRAME + 4) tick();
    check("lost_pending_ready", 32'(bus.o_ready), 32'd1);

    // 1234 commits at the next boundary; ABCD held while not ready follows one frame later
    send(tbl[0].data);
    check("ready_fall", 32'(bus.o_ready), 32'd0);
    bus.iv_data = tbl[1].data;
    bus.i_valid = 1'b1;
    wait_ready(cyc);
    check_frame(0);
    wait_ready(cyc);
    check("abcd_commit_wait", 32'(cyc), 32'd1);
    check_frame(1);

    // Transfer exactly on the frame-boundary cycle: old value stays for one more frame
    check("pre_boundary_ready", 32'(bus.o_ready), 32'd1);
    send(tbl[2].data);
    check_frame(1);
    wait_ready(cyc);
    check("boundary_xfer_wait", 32'(cyc), 32'd1);
    check_frame(2);

    // Enable dropped for 10 cycles mid-slot
    repeat (3) tick();
    i_enable = 1'b0;
    tick();
    check("en_off_digit_n", 32'(ov_digit_n), 32'hF);
    repeat (9) tick();
    i_enable = 1'b1;
    repeat (FRAME) tick();

    // Table rows (leading-zero cases)
    for (int r = 3; r < 6; r++) begin
      send(tbl[r].data);
      wait_ready(cyc);
      check("tbl_latency", 32'(cyc <= FRAME), 32'd1);
      check_frame(r);
    end

    // Randomized traffic and enable toggling against the model
    for (int i = 0; i < 1200; i++) begin
      if (bus.i_valid && m_xfer) bus.i_valid = 1'b0;
      if (!bus.i_valid && $urandom_range(0, 7) == 0) begin
        bus.iv_data = 16'($urandom);
        bus.i_valid = 1'b1;
      end
      if ($urandom_range(0, 39) == 0) i_enable = ~i_enable;
      tick();
      if (i == 600) do_reset();
    end
    i_enable    = 1'b1;
    bus.i_valid = 1'b0;
    repeat (FRAME) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
